// File: rtl/hpdmc_dqcal_pkg.sv
// Shared types and constants for the per-lane DQ read-capture calibration engine.
// Holds the global FSM encoding, timing constants and the beat comparison helper.
package hpdmc_dqcal_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CAL,
    S_WCAL,
    S_RST,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_STEP_WAIT,
    S_CENTRE,
    S_DONE
  } state_t;

  localparam int          CNT_W       = 16;
  // IODELAY BUSY may only rise a cycle after the strobe, so never trust it sooner.
  localparam int          BUSY_HOLD   = 2;
  localparam logic [15:0] DEF_PATTERN = 16'h55AA;

  function automatic logic beat_mismatch(input logic [7:0]  rise,
                                         input logic [7:0]  fall,
                                         input logic [15:0] pattern);
    return ({fall, rise} != pattern);
  endfunction

endpackage

// File: rtl/hpdmc_dqcal_lane.sv
// One byte lane of the DQ calibration engine: tap counter, per-tap pass/fail over a
// burst of training beats, first passing window, centre target and IODELAY strobes.
module hpdmc_dqcal_lane
  import hpdmc_dqcal_pkg::*;
#(
  parameter int          TAP_BITS   = 8,
  parameter int          MAX_TAP    = 255,
  parameter int          MIN_WINDOW = 8,
  parameter logic [15:0] PATTERN    = DEF_PATTERN
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clear_i,
  input  logic                beat_i,
  input  logic                last_i,
  input  logic                step_i,
  input  logic                centre_init_i,
  input  logic                centre_en_i,
  input  logic [7:0]          rise_i,
  input  logic [7:0]          fall_i,
  input  logic                busy_i,
  output logic [TAP_BITS-1:0] tap_o,
  output logic                active_o,
  output logic                at_target_o,
  output logic                fail_o,
  output logic                ce_o,
  output logic                inc_o
);

  localparam logic [TAP_BITS-1:0] MAX_T = TAP_BITS'(MAX_TAP);
  localparam logic [TAP_BITS:0]   MIN_W = (TAP_BITS + 1)'(MIN_WINDOW);

  logic [TAP_BITS-1:0] tap_q;
  logic [TAP_BITS-1:0] win_start_q;
  logic [TAP_BITS-1:0] win_end_q;
  logic [TAP_BITS-1:0] target_q;
  logic                found_q;
  logic                scanning_q;
  logic                mism_q;
  logic                fail_q;
  logic [1:0]          hold_q;

  logic                beat_bad;
  logic                tap_pass;
  logic                step_ce;
  logic                centre_ce;
  logic [TAP_BITS:0]   win_sum;
  logic [TAP_BITS:0]   win_width;
  logic                narrow;
  logic [TAP_BITS-1:0] centre_tap;

  assign beat_bad = beat_mismatch(rise_i, fall_i, PATTERN);
  assign tap_pass = !(mism_q || beat_bad);

  assign active_o    = scanning_q && (tap_q != MAX_T);
  assign step_ce     = step_i && active_o && !busy_i;
  assign centre_ce   = centre_en_i && (tap_q != target_q) && (hold_q == 2'd0) && !busy_i;
  assign ce_o        = step_ce || centre_ce;
  assign inc_o       = step_ce;
  assign at_target_o = (tap_q == target_q) && (hold_q == 2'd0) && !busy_i;
  assign tap_o       = tap_q;
  assign fail_o      = fail_q;

  // Extra bit keeps the window sum and width exact at the top of the tap range.
  always_comb begin
    win_sum    = {1'b0, win_start_q} + {1'b0, win_end_q};
    win_width  = {1'b0, win_end_q} - {1'b0, win_start_q} + 1'b1;
    narrow     = !found_q || (win_width < MIN_W);
    centre_tap = narrow ? '0 : win_sum[TAP_BITS:1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tap_q       <= '0;
      win_start_q <= '0;
      win_end_q   <= '0;
      target_q    <= '0;
      found_q     <= 1'b0;
      scanning_q  <= 1'b0;
      mism_q      <= 1'b0;
      fail_q      <= 1'b0;
      hold_q      <= 2'd0;
    end else if (clear_i) begin
      tap_q       <= '0;
      win_start_q <= '0;
      win_end_q   <= '0;
      target_q    <= '0;
      found_q     <= 1'b0;
      scanning_q  <= 1'b1;
      mism_q      <= 1'b0;
      fail_q      <= 1'b0;
      hold_q      <= 2'd0;
    end else begin
      if (ce_o) begin
        tap_q  <= inc_o ? tap_q + 1'b1 : tap_q - 1'b1;
        hold_q <= 2'(BUSY_HOLD);
      end else if (hold_q != 2'd0) begin
        hold_q <= hold_q - 1'b1;
      end

      if (beat_i) begin
        if (last_i) begin
          mism_q <= 1'b0;
          if (scanning_q) begin
            if (tap_pass) begin
              if (!found_q) begin
                found_q     <= 1'b1;
                win_start_q <= tap_q;
              end
              win_end_q <= tap_q;
            end else if (found_q) begin
              scanning_q <= 1'b0;
            end
            // The last tap is evaluated once; an open window closes here.
            if (tap_q == MAX_T) begin
              scanning_q <= 1'b0;
            end
          end
        end else begin
          mism_q <= mism_q || beat_bad;
        end
      end

      if (centre_init_i) begin
        target_q <= centre_tap;
        fail_q   <= narrow;
      end
    end
  end

endmodule

// File: rtl/hpdmc_dqcal.sv
// DDR read-capture calibration top: global sweep FSM, settle/sample counters and the
// shared IODELAY cal/rst pulses, driving NLANES independent lane engines.
module hpdmc_dqcal
  import hpdmc_dqcal_pkg::*;
#(
  parameter int          NLANES     = 2,
  parameter int          TAP_BITS   = 8,
  parameter int          MAX_TAP    = 255,
  parameter int          SETTLE     = 16,
  parameter int          SAMPLES    = 4,
  parameter int          MIN_WINDOW = 8,
  parameter logic [15:0] PATTERN    = DEF_PATTERN
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_n_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NLANES-1:0]          lane_fail_o,
  output logic [NLANES*TAP_BITS-1:0] tap_o,
  input  logic [16*NLANES-1:0]       di_i,
  input  logic                       di_valid_i,
  input  logic [NLANES-1:0]          idelay_busy_i,
  output logic                       idelay_rst_o,
  output logic                       idelay_cal_o,
  output logic [NLANES-1:0]          idelay_ce_o,
  output logic [NLANES-1:0]          idelay_inc_o
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         rst_sync_q;
  logic               rst_n_sync;

  logic               lane_clear;
  logic               sample_beat;
  logic               sample_last;
  logic               step_en;
  logic               centre_init;
  logic               centre_en;
  logic               cal_pulse;
  logic               rst_pulse;
  logic               done_pulse;
  logic [NLANES-1:0]  lane_active;
  logic [NLANES-1:0]  lane_at_target;
  logic               any_active;
  logic               all_at_target;
  logic               all_idle;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_sync = rst_sync_q[1];

  assign any_active    = |lane_active;
  assign all_at_target = &lane_at_target;
  assign all_idle      = ~|idelay_busy_i;

  always_ff @(posedge sys_clk_i or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_clear  = 1'b0;
    sample_beat = 1'b0;
    sample_last = 1'b0;
    step_en     = 1'b0;
    centre_init = 1'b0;
    centre_en   = 1'b0;
    cal_pulse   = 1'b0;
    rst_pulse   = 1'b0;
    done_pulse  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CAL;
        end
      end
      S_CAL: begin
        cal_pulse  = 1'b1;
        lane_clear = 1'b1;
        cnt_d      = CNT_W'(BUSY_HOLD);
        state_d    = S_WCAL;
      end
      S_WCAL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (all_idle) begin
          state_d = S_RST;
        end
      end
      S_RST: begin
        rst_pulse  = 1'b1;
        lane_clear = 1'b1;
        cnt_d      = CNT_W'(SETTLE - 1);
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Only beats flagged valid advance the sample count.
      S_SAMPLE: begin
        if (di_valid_i) begin
          sample_beat = 1'b1;
          if (cnt_q == CNT_W'(SAMPLES - 1)) begin
            sample_last = 1'b1;
            cnt_d       = '0;
            state_d     = S_STEP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_STEP: begin
        if (any_active) begin
          step_en = 1'b1;
          cnt_d   = CNT_W'(BUSY_HOLD);
          state_d = S_STEP_WAIT;
        end else begin
          centre_init = 1'b1;
          state_d     = S_CENTRE;
        end
      end
      S_STEP_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (all_idle) begin
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = S_SETTLE;
        end
      end
      S_CENTRE: begin
        centre_en = 1'b1;
        if (all_at_target) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_pulse = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = done_pulse;
  assign idelay_cal_o = cal_pulse;
  assign idelay_rst_o = rst_pulse;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    hpdmc_dqcal_lane #(
      .TAP_BITS  (TAP_BITS),
      .MAX_TAP   (MAX_TAP),
      .MIN_WINDOW(MIN_WINDOW),
      .PATTERN   (PATTERN)
    ) u_lane (
      .clk_i        (sys_clk_i),
      .rst_n_i      (rst_n_sync),
      .clear_i      (lane_clear),
      .beat_i       (sample_beat),
      .last_i       (sample_last),
      .step_i       (step_en),
      .centre_init_i(centre_init),
      .centre_en_i  (centre_en),
      .rise_i       (di_i[8*gi +: 8]),
      .fall_i       (di_i[8*NLANES + 8*gi +: 8]),
      .busy_i       (idelay_busy_i[gi]),
      .tap_o        (tap_o[gi*TAP_BITS +: TAP_BITS]),
      .active_o     (lane_active[gi]),
      .at_target_o  (lane_at_target[gi]),
      .fail_o       (lane_fail_o[gi]),
      .ce_o         (idelay_ce_o[gi]),
      .inc_o        (idelay_inc_o[gi])
    );
  end

endmodule

// File: tb/tb_hpdmc_dqcal.sv
// Scoreboard bench for hpdmc_dqcal: IODELAY stub plus windowed training-data model,
// directed calibration runs with hand-computed final taps and lane_fail flags.
module tb_hpdmc_dqcal;

  localparam int NL   = 2;
  localparam int TB   = 8;
  localparam int MAXT = 63;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, irst, ical;
  logic [NL-1:0]     lane_fail, ibusy, ce, inc;
  logic [NL*TB-1:0]  tap;
  logic [16*NL-1:0]  di = '0;
  logic              di_valid = 1'b0;

  always #5 clk = ~clk;

  hpdmc_dqcal #(
    .NLANES(NL), .TAP_BITS(TB), .MAX_TAP(MAXT), .SETTLE(4),
    .SAMPLES(4), .MIN_WINDOW(8), .PATTERN(16'h55AA)
  ) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .start_i(start), .busy_o(busy),
    .done_o(done), .lane_fail_o(lane_fail), .tap_o(tap), .di_i(di),
    .di_valid_i(di_valid), .idelay_busy_i(ibusy), .idelay_rst_o(irst),
    .idelay_cal_o(ical), .idelay_ce_o(ce), .idelay_inc_o(inc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // IODELAY stub: BUSY for 3 cycles after every CE or CAL.
  int stub_tap[NL] = '{default: 0};
  int busy_cnt[NL] = '{default: 0};
  int cal_cnt = 0;
  int rst_cnt = 0;
  int viol = 0;

  always @(posedge clk) begin
    if (ical) cal_cnt <= cal_cnt + 1;
    if (irst) rst_cnt <= rst_cnt + 1;
    for (int l = 0; l < NL; l++) begin
      if (irst) stub_tap[l] <= 0;
      else if (ce[l]) stub_tap[l] <= inc[l] ? stub_tap[l] + 1 : stub_tap[l] - 1;
      if (ce[l] || ical) busy_cnt[l] <= 3;
      else if (busy_cnt[l] > 0) busy_cnt[l] <= busy_cnt[l] - 1;
    end
  end

  always_comb begin
    for (int l = 0; l < NL; l++) ibusy[l] = (busy_cnt[l] != 0);
  end

  // Training-data model: lane l passes taps [win_a, win_b]; one valid beat in four
  // is corrupted at bad_tap on lane 0; gap_mode inserts idle cycles with junk data.
  int win_a[NL];
  int win_b[NL];
  int bad_tap = -1;
  bit gap_mode = 1'b0;
  int cyc = 0;
  int beat_idx = 0;
  int last_tap0 = 0;

  always @(negedge clk) begin
    logic v, good;
    int t;
    cyc++;
    v = gap_mode ? ((cyc % 3) != 1) : 1'b1;
    di_valid = v;
    if (stub_tap[0] != last_tap0) beat_idx = 0;
    last_tap0 = stub_tap[0];
    for (int l = 0; l < NL; l++) begin
      t = stub_tap[l];
      if (!v) begin
        di[8*l +: 8]      = 8'h00;
        di[8*NL+8*l +: 8] = 8'h00;
      end else begin
        good = (t >= win_a[l]) && (t <= win_b[l]);
        if (l == 0 && t == bad_tap) begin
          if ((beat_idx % 4) == 2) good = 1'b0;
          beat_idx++;
        end
        di[8*l +: 8]      = (good || (t % 2) == 1) ? 8'hAA : 8'hAB;
        di[8*NL+8*l +: 8] = (good || (t % 2) == 0) ? 8'h55 : 8'h54;
      end
    end
  end

  typedef struct {
    logic [1:0] fail;
    int         t0;
    int         t1;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: protocol watch every cycle, scoreboard pop on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int l = 0; l < NL; l++) begin
      if (ce[l] && ibusy[l]) begin
        viol++;
        $display("[TB] FAIL ce_while_busy lane %0d at tap %0d", l, stub_tap[l]);
      end
      if (ce[l] && inc[l] && stub_tap[l] >= MAXT) begin
        viol++;
        $display("[TB] FAIL tap_overflow lane %0d: tap %0d, limit %0d", l, stub_tap[l], MAXT);
      end
      if (ce[l] && !inc[l] && stub_tap[l] <= 0) begin
        viol++;
        $display("[TB] FAIL tap_underflow lane %0d: tap %0d, limit 0", l, stub_tap[l]);
      end
    end
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("lane_fail", int'(lane_fail), int'(e.fail));
        check("tap0", int'(tap[0 +: TB]), e.t0);
        check("tap1", int'(tap[TB +: TB]), e.t1);
        $display("[TB] done: lane_fail=%b tap0=%0d tap1=%0d (expected %b %0d %0d)",
                 lane_fail, tap[0 +: TB], tap[TB +: TB], e.fail, e.t0, e.t1);
      end
    end
  end

  task automatic set_win(input int a0, input int b0, input int a1, input int b1);
    win_a[0] = a0; win_b[0] = b0;
    win_a[1] = a1; win_b[1] = b1;
  endtask

  task automatic run_cal(input logic [1:0] ef, input int e0, input int e1, input bit poke);
    exp_t e;
    int c0, r0, v0;
    bit seen;
    e.fail = ef; e.t0 = e0; e.t1 = e1;
    sb_q.push_back(e);
    c0 = cal_cnt; r0 = rst_cnt; v0 = viol;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    seen = 1'b0;
    for (int k = 0; k < 8000 && !seen; k++) begin
      @(negedge clk);
      start = (poke && k == 200);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      e = sb_q.pop_back();
      start = 1'b0;
    end else begin
      // start in the done cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", int'(busy), 0);
      check("done_one_cycle", int'(done), 0);
    end
    check("cal_pulses", cal_cnt - c0, 1);
    check("rst_pulses", rst_cnt - r0, 1);
    check("protocol_violations", viol - v0, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit seen;
    set_win(10, 30, 20, 45);
    repeat (3) @(negedge clk);
    check("reset_busy_done", int'({busy, done}), 0);
    check("reset_tap", int'(tap), 0);
    check("reset_fail", int'(lane_fail), 0);
    check("reset_strobes", int'({ce, inc, irst, ical}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: both lanes pass, start poked mid-sweep
    set_win(10, 30, 20, 45);
    run_cal(2'b00, 20, 32, 1'b1);
    // 2: lane 1 never passes
    set_win(10, 30, 1, 0);
    run_cal(2'b10, 20, 0, 1'b0);
    // 3a: lane 0 window open at MAX_TAP, width 6 < 8
    set_win(58, 63, 20, 45);
    run_cal(2'b01, 0, 32, 1'b0);
    // 3b: lane 0 window open at MAX_TAP, width exactly 8
    set_win(56, 63, 20, 45);
    run_cal(2'b00, 59, 32, 1'b0);
    // 4: one bad beat in four at tap 25 with idle gaps -> window [10,24]
    gap_mode = 1'b1;
    bad_tap  = 25;
    set_win(10, 30, 20, 45);
    run_cal(2'b00, 17, 32, 1'b0);
    gap_mode = 1'b0;
    bad_tap  = -1;

    // 5: reset while centring, then a clean recalibration
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8000 && !seen; k++) begin
      @(negedge clk);
      if (|(ce & ~inc)) seen = 1'b1;
    end
    check("centre_reached", int'(seen), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy_done", int'({busy, done}), 0);
    check("midrst_tap", int'(tap), 0);
    check("midrst_fail", int'(lane_fail), 0);
    check("midrst_strobes", int'({ce, inc, irst, ical}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_cal(2'b00, 20, 32, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
